// File: rtl/exec_mem_unit.sv
// Execute/memory stage: combinational ALU feeding a word-addressed data memory with an optional IO window.
// Define EXEC_MEM_IO_EN to decode alu_result[31] as the IO region; otherwise every address maps to memory.
module exec_mem_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    input  logic        data_read_en,
    input  logic        data_write_en,
    input  logic [31:0] data_write_value,
    output logic [31:0] data_read_value,
    output logic        is_io,
    output logic [31:0] io_address,
    output logic [31:0] io_write_value,
    output logic        io_read_en,
    output logic        io_write_en,
    input  logic [31:0] io_read_value
);

    localparam int ADDR_W = $clog2(MEM_WORDS);

    logic [31:0]       mem_r [MEM_WORDS];
    logic [ADDR_W-1:0] word_idx_s;
    logic              is_io_s;
    logic              mem_read_en_s;
    logic              mem_write_en_s;
    logic [31:0]       mem_read_data_s;

    // ALU operation decode; unknown codes produce zero
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = alu_a << alu_b[4:0];
            4'b0110: alu_result = alu_a >> alu_b[4:0];
            4'b0111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1000: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1001: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'b1010: alu_result = alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    // Zero flag from the ALU result
    always_comb begin
        zero = (alu_result == 32'd0);
    end

    // Address decode steering the request to memory or IO
    always_comb begin
        word_idx_s     = alu_result[ADDR_W+1:2];
`ifdef EXEC_MEM_IO_EN
        is_io_s        = alu_result[31];
`else
        is_io_s        = 1'b0;
`endif
        mem_read_en_s  = data_read_en & ~is_io_s;
        mem_write_en_s = data_write_en & ~is_io_s;
        is_io          = is_io_s;
        if (is_io_s) begin
            io_address     = alu_result;
            io_write_value = data_write_value;
            io_read_en     = data_read_en;
            io_write_en    = data_write_en;
        end else begin
            io_address     = 32'd0;
            io_write_value = 32'd0;
            io_read_en     = 1'b0;
            io_write_en    = 1'b0;
        end
    end

    // Data memory: cleared asynchronously while in reset, one word written per cycle otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (mem_write_en_s) begin
            mem_r[word_idx_s] <= data_write_value;
        end
    end

    // Zero-latency read; a same-cycle write is only visible after the edge
    always_comb begin
        if (mem_read_en_s) begin
            mem_read_data_s = mem_r[word_idx_s];
        end else begin
            mem_read_data_s = 32'd0;
        end
        if (is_io_s) begin
            data_read_value = io_read_value;
        end else begin
            data_read_value = mem_read_data_s;
        end
    end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit; IO checks follow the EXEC_MEM_IO_EN build setting.
module tb_exec_mem_unit;

    localparam int MEM_WORDS = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic        data_read_en;
    logic        data_write_en;
    logic [31:0] data_write_value;
    logic [31:0] data_read_value;
    logic        is_io;
    logic [31:0] io_address;
    logic [31:0] io_write_value;
    logic        io_read_en;
    logic        io_write_en;
    logic [31:0] io_read_value;

    int pass_cnt;
    int total_cnt;

    exec_mem_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_control      (alu_control),
        .alu_result       (alu_result),
        .zero             (zero),
        .data_read_en     (data_read_en),
        .data_write_en    (data_write_en),
        .data_write_value (data_write_value),
        .data_read_value  (data_read_value),
        .is_io            (is_io),
        .io_address       (io_address),
        .io_write_value   (io_write_value),
        .io_read_en       (io_read_en),
        .io_write_en      (io_write_en),
        .io_read_value    (io_read_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] addr);
        alu_a       = addr;
        alu_b       = 32'd0;
        alu_control = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_a = 32'd0; alu_b = 32'd0; alu_control = 4'b0000;
        data_read_en = 1'b0; data_write_en = 1'b0;
        data_write_value = 32'd0; io_read_value = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        data_read_en = 1'b1;
        set_addr(32'h0000_0040);
        #1;
        total_cnt++;
        if (data_read_value !== 32'd0) $display("FAIL reset_read: got %h expected %h", data_read_value, 32'd0);
        else pass_cnt++;
        total_cnt++;
        if (zero !== 1'b0) $display("FAIL reset_zero: got %b expected %b", zero, 1'b0);
        else pass_cnt++;
        data_read_en = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] va [14];
        logic [31:0] vb [14];
        logic [3:0]  vc [14];
        logic [31:0] ve [14];
        va[0]  = 32'd5;         vb[0]  = 32'd5;         vc[0]  = 4'b0001; ve[0]  = 32'd0;
        va[1]  = 32'hFFFF_FFFF; vb[1]  = 32'd1;         vc[1]  = 4'b1000; ve[1]  = 32'd1;
        va[2]  = 32'hFFFF_FFFF; vb[2]  = 32'd1;         vc[2]  = 4'b1001; ve[2]  = 32'd0;
        va[3]  = 32'h8000_0000; vb[3]  = 32'd4;         vc[3]  = 4'b0111; ve[3]  = 32'hF800_0000;
        va[4]  = 32'h8000_0000; vb[4]  = 32'd4;         vc[4]  = 4'b0110; ve[4]  = 32'h0800_0000;
        va[5]  = 32'hFFFF_FFFF; vb[5]  = 32'd2;         vc[5]  = 4'b0000; ve[5]  = 32'd1;
        va[6]  = 32'd3;         vb[6]  = 32'd5;         vc[6]  = 4'b0001; ve[6]  = 32'hFFFF_FFFE;
        va[7]  = 32'hF0F0_1234; vb[7]  = 32'h0FF0_FF00; vc[7]  = 4'b0010; ve[7]  = 32'h00F0_1200;
        va[8]  = 32'hF0F0_1234; vb[8]  = 32'h0FF0_FF00; vc[8]  = 4'b0011; ve[8]  = 32'hFFF0_FF34;
        va[9]  = 32'hF0F0_1234; vb[9]  = 32'h0FF0_FF00; vc[9]  = 4'b0100; ve[9]  = 32'hFF00_ED34;
        va[10] = 32'd1;         vb[10] = 32'h0000_003F; vc[10] = 4'b0101; ve[10] = 32'h8000_0000;
        va[11] = 32'd1;         vb[11] = 32'hFFFF_FFFF; vc[11] = 4'b1000; ve[11] = 32'd0;
        va[12] = 32'h1234_5678; vb[12] = 32'hCAFE_F00D; vc[12] = 4'b1010; ve[12] = 32'hCAFE_F00D;
        va[13] = 32'h1234_5678; vb[13] = 32'hCAFE_F00D; vc[13] = 4'b1111; ve[13] = 32'd0;
        for (int i = 0; i < 14; i++) begin
            alu_a = va[i]; alu_b = vb[i]; alu_control = vc[i];
            #1;
            total_cnt++;
            if (alu_result !== ve[i]) $display("FAIL alu_vec%0d: got %h expected %h", i, alu_result, ve[i]);
            else pass_cnt++;
            total_cnt++;
            if (zero !== (ve[i] == 32'd0)) $display("FAIL zero_vec%0d: got %b expected %b", i, zero, (ve[i] == 32'd0));
            else pass_cnt++;
        end
    endtask

    task automatic test_store_wrap();
        alu_a = 32'h0000_000C; alu_b = 32'd4; alu_control = 4'b0000;
        data_write_en = 1'b1; data_write_value = 32'hDEAD_BEEF;
        tick();
        data_write_en = 1'b0; data_read_en = 1'b1;
        #1;
        total_cnt++;
        if (data_read_value !== 32'hDEAD_BEEF) $display("FAIL store_read: got %h expected %h", data_read_value, 32'hDEAD_BEEF);
        else pass_cnt++;
        set_addr(32'h10 + 32'(4 * MEM_WORDS));
        #1;
        total_cnt++;
        if (data_read_value !== 32'hDEAD_BEEF) $display("FAIL store_wrap: got %h expected %h", data_read_value, 32'hDEAD_BEEF);
        else pass_cnt++;
        set_addr(32'h0000_0013);
        #1;
        total_cnt++;
        if (data_read_value !== 32'hDEAD_BEEF) $display("FAIL store_lowbits: got %h expected %h", data_read_value, 32'hDEAD_BEEF);
        else pass_cnt++;
        data_read_en = 1'b0;
        #1;
        total_cnt++;
        if (data_read_value !== 32'd0) $display("FAIL read_disabled: got %h expected %h", data_read_value, 32'd0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        set_addr(32'h0000_0020);
        data_write_en = 1'b1; data_write_value = 32'h1111_1111;
        tick();
        data_write_value = 32'h2222_2222;
        tick();
        data_write_value = 32'h3333_3333; data_read_en = 1'b1;
        #1;
        total_cnt++;
        if (data_read_value !== 32'h2222_2222) $display("FAIL rw_old: got %h expected %h", data_read_value, 32'h2222_2222);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (data_read_value !== 32'h3333_3333) $display("FAIL rw_new: got %h expected %h", data_read_value, 32'h3333_3333);
        else pass_cnt++;
        data_write_en = 1'b0; data_read_en = 1'b0;
    endtask

    task automatic test_io();
        set_addr(32'h0000_0004);
        data_write_en = 1'b1; data_write_value = 32'h0000_0099;
        tick();
        set_addr(32'h8000_0004);
        data_write_value = 32'h0000_0055;
        #1;
`ifdef EXEC_MEM_IO_EN
        total_cnt++;
        if (io_write_en !== 1'b1) $display("FAIL io_write_en: got %b expected %b", io_write_en, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (io_address !== 32'h8000_0004) $display("FAIL io_address: got %h expected %h", io_address, 32'h8000_0004);
        else pass_cnt++;
        total_cnt++;
        if (io_write_value !== 32'h0000_0055) $display("FAIL io_write_value: got %h expected %h", io_write_value, 32'h0000_0055);
        else pass_cnt++;
        tick();
        data_write_en = 1'b0; data_read_en = 1'b1; io_read_value = 32'h0000_1234;
        #1;
        total_cnt++;
        if (data_read_value !== 32'h0000_1234) $display("FAIL io_read: got %h expected %h", data_read_value, 32'h0000_1234);
        else pass_cnt++;
        total_cnt++;
        if (io_read_en !== 1'b1) $display("FAIL io_read_en: got %b expected %b", io_read_en, 1'b1);
        else pass_cnt++;
        set_addr(32'h0000_0004);
        #1;
        total_cnt++;
        if (data_read_value !== 32'h0000_0099) $display("FAIL io_mem_untouched: got %h expected %h", data_read_value, 32'h0000_0099);
        else pass_cnt++;
`else
        total_cnt++;
        if (io_write_en !== 1'b0) $display("FAIL noio_write_en: got %b expected %b", io_write_en, 1'b0);
        else pass_cnt++;
        total_cnt++;
        if (io_address !== 32'd0) $display("FAIL noio_address: got %h expected %h", io_address, 32'd0);
        else pass_cnt++;
        tick();
        data_write_en = 1'b0; data_read_en = 1'b1; io_read_value = 32'h0000_1234;
        #1;
        total_cnt++;
        if (data_read_value !== 32'h0000_0055) $display("FAIL noio_mem_word1: got %h expected %h", data_read_value, 32'h0000_0055);
        else pass_cnt++;
        set_addr(32'h8000_0008);
        data_read_en = 1'b0; data_write_en = 1'b1; data_write_value = 32'h0000_0077;
        #1;
        total_cnt++;
        if (is_io !== 1'b0) $display("FAIL noio_is_io: got %b expected %b", is_io, 1'b0);
        else pass_cnt++;
        tick();
        data_write_en = 1'b0; data_read_en = 1'b1;
        set_addr(32'h0000_0008);
        #1;
        total_cnt++;
        if (data_read_value !== 32'h0000_0077) $display("FAIL noio_mem_word2: got %h expected %h", data_read_value, 32'h0000_0077);
        else pass_cnt++;
`endif
        data_read_en = 1'b0; data_write_en = 1'b0; io_read_value = 32'd0;
    endtask

    task automatic test_reset_clear();
        set_addr(32'h0000_000C);
        data_write_en = 1'b1; data_write_value = 32'h0000_00A5;
        tick();
        data_write_en = 1'b0; data_read_en = 1'b1;
        #1;
        total_cnt++;
        if (data_read_value !== 32'h0000_00A5) $display("FAIL word3_before_rst: got %h expected %h", data_read_value, 32'h0000_00A5);
        else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (data_read_value !== 32'd0) $display("FAIL word3_async_clear: got %h expected %h", data_read_value, 32'd0);
        else pass_cnt++;
        data_write_en = 1'b1; data_write_value = 32'h0000_00FF;
        tick();
        data_write_en = 1'b0;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (data_read_value !== 32'd0) $display("FAIL write_in_rst: got %h expected %h", data_read_value, 32'd0);
        else pass_cnt++;
        set_addr(32'h0000_0010);
        #1;
        total_cnt++;
        if (data_read_value !== 32'd0) $display("FAIL word4_cleared: got %h expected %h", data_read_value, 32'd0);
        else pass_cnt++;
        data_read_en = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_alu();
        test_store_wrap();
        test_back_to_back();
        test_io();
        test_reset_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit data-memory words; SHALL be a power of two, 4..1024.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_a  input  32  ALU operand A.
REQ-005 alu_b  input  32  ALU operand B.
REQ-006 alu_control  input  4  ALU operation select.
REQ-007 alu_result  output  32  ALU result; also the data address.
REQ-008 zero  output  1  high when alu_result == 0.
REQ-009 data_read_en / data_write_en  input  1 each  load / store request for the current address.
REQ-010 data_write_value  input  32  store data.
REQ-011 data_read_value  output  32  load data, muxed from memory or IO.
REQ-012 is_io  output  1  current address decodes to the IO region.
REQ-013 io_address  output  32; io_write_value  output  32; io_read_en / io_write_en  output  1 each; io_read_value  input  32.

Function
REQ-014 ALU SHALL be purely combinational: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed, result 1/0), 1001 SLTU, 1010 pass alu_b, other codes result 0.
REQ-015 ADD/SUB SHALL wrap modulo 2^32 with no flags other than zero; shift amount SHALL be alu_b[4:0].
REQ-016 is_io SHALL equal alu_result[31]; addresses 0x0000_0000-0x7FFF_FFFF are memory, 0x8000_0000-0xFFFF_FFFF are IO.
REQ-017 For memory addresses: mem_read_en = data_read_en, mem_write_en = data_write_en; all io_* outputs SHALL be 0.
REQ-018 For IO addresses: io_address = alu_result, io_read_en = data_read_en, io_write_en = data_write_en, io_write_value = data_write_value; memory read and write enables SHALL be 0.
REQ-019 Memory word index SHALL be alu_result[log2(MEM_WORDS)+1:2]; address bits [1:0] and higher bits are ignored, so accesses wrap within the memory.
REQ-020 Memory write SHALL occur on the rising clk edge when the write enable is high and rst_n is high; one word per cycle.
REQ-021 Memory read SHALL be combinational (zero latency); when the read enable is low, memory read data SHALL be 0.
REQ-022 data_read_value SHALL equal io_read_value when is_io is high, else memory read data.
REQ-023 With simultaneous read and write to the same word, the read SHALL return the old value until the clock edge, then the new value.
REQ-024 Combined data_read_en and data_write_en SHALL both act (read old, write new), with no error flag.

Reset
REQ-025 While rst_n is low, every memory word SHALL be cleared to 0 asynchronously, and writes SHALL be ignored.
REQ-026 All outputs are combinational; after reset, a memory read SHALL return 0 and all other outputs follow their inputs.

Configuration
REQ-027 Macro EXEC_MEM_IO_EN: when defined, IO decoding SHALL behave per REQ-016 to REQ-018 and REQ-022.
REQ-028 When EXEC_MEM_IO_EN is undefined, is_io and all io_* outputs SHALL be tied to 0, every address SHALL map to memory, and io_read_value SHALL be ignored.

Verification
REQ-029 alu_a=5, alu_b=5, alu_control=0001 -> alu_result=0, zero=1; alu_control=1000 with alu_a=0xFFFFFFFF, alu_b=1 -> result 1; with 1001 -> result 0.
REQ-030 alu_control=0111, alu_a=0x80000000, alu_b=4 -> alu_result 0xF8000000; with 0110 -> 0x08000000.
REQ-031 Store 0xDEADBEEF at address 0x10 (ADD 0x0C+0x04, data_write_en=1, one clk) -> a read at 0x10 returns 0xDEADBEEF; a read at 0x10+4*MEM_WORDS also returns 0xDEADBEEF (wrap).
REQ-032 Address 0x80000004, data_write_en=1, data_write_value=0x55 with EXEC_MEM_IO_EN defined -> io_write_en=1, io_address=0x80000004, io_write_value=0x55, and memory word 1 is unchanged; with data_read_en=1 and io_read_value=0x1234 -> data_read_value=0x1234.
REQ-033 Write 0xA5 to word 3, then pulse rst_n low mid-cycle -> read of word 3 returns 0 immediately after assertion; a write attempted while rst_n is low has no effect.
REQ-034 Build without EXEC_MEM_IO_EN: a store to 0x80000008 -> is_io=0, io_write_en=0, and memory word 2 holds the store data.
